key_step_ctrl: RTL
==================

# key_step_ctrl

Sequencer between the debounced up/down key levels and the 8-bit up/down key counter. It converts key presses into single-cycle step pulses that drive the counter's increment and decrement inputs. It adds hold-to-repeat, locks out conflicting presses, and suppresses steps that would push the counter past its limits. It sits between the key debouncers and the counter that feeds the seven-segment display.

## Interface

- HOLD_CYC, 24'd5_000_000: cycles from the first step until auto-repeat starts; must be ≥ 2.
- REPEAT_CYC, 24'd2_500_000: cycles between auto-repeat steps; must be ≥ 2.
- CNT_MAX, 8'd255: upper limit; no step_up is issued when cnt_val ≥ CNT_MAX.
- CNT_MIN, 8'd0: lower limit; no step_dn is issued when cnt_val ≤ CNT_MIN.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_up  input  1  debounced up-key level; 1 = pressed.
- key_dn  input  1  debounced down-key level; 1 = pressed.
- cnt_val  input  8  current counter value, fed back from the counter.
- step_up  output  1  one-cycle increment pulse to the counter.
- step_dn  output  1  one-cycle decrement pulse to the counter.
- sat  output  1  registered flag: 1 when a requested step was suppressed at a limit.
- state  output  3  current FSM state encoding, for debug.

## Operation

- FSM states and encodings: IDLE=0, HOLD=1, REPEAT=2, LOCK=3.
- An internal owner bit records which key started the sequence. A 24-bit timer tracks cycles within HOLD and REPEAT.
- IDLE:
  - Exactly one key high: request a step for that key, set owner, clear the timer, go to HOLD.
  - Both keys high: go to LOCK. No step is issued.
- HOLD:
  - Owner key low: go to IDLE. No step.
  - Else the non-owner key high: go to LOCK. No step.
  - Else timer == HOLD_CYC-1: request a step, clear the timer, go to REPEAT.
  - Else increment the timer.
- REPEAT: same priority order as HOLD, using REPEAT_CYC-1 as the expiry value. On expiry the FSM stays in REPEAT.
- LOCK: remains until both keys are low, then goes to IDLE. No steps are issued in LOCK.
- Step request and saturation:
  - An up request drives step_up=1 for one cycle only if cnt_val < CNT_MAX. Otherwise step_up stays 0 and sat=1 for that cycle.
  - Down requests behave the same way, using cnt_val > CNT_MIN.
- step_up and step_dn are never high in the same cycle.
- The counter updates one cycle after a step. Requiring REPEAT_CYC ≥ 2 guarantees cnt_val has settled before the next limit check, so there is no overshoot.

## Timing

- Reset (rst=1, asynchronous): state=IDLE, step_up=0, step_dn=0, sat=0, timer=0, owner=0.
- Reset asserted mid-sequence aborts immediately, with no trailing pulse.
- After reset releases, a key still held is treated as a new press on the first sampling edge.
- All outputs are registered.
- First-step latency: a key sampled high at edge k in IDLE produces a step high from edge k to edge k+1.
- The second step occurs HOLD_CYC cycles after the first. Later steps are spaced REPEAT_CYC cycles apart.
- Release takes priority over timer expiry: a key sampled low at the expiry edge produces no step.
- cnt_val is sampled at the same edge that issues the step.

## Configuration

- KEY_REPEAT_EN defined: full behaviour as described above.
- KEY_REPEAT_EN undefined:
  - HOLD and REPEAT collapse into a single wait-for-release state. The timer logic is removed.
  - Each press yields exactly one step.
  - The lockout and saturation rules are unchanged.

## Test plan

Benches use HOLD_CYC=10 and REPEAT_CYC=4.

- Reset, then a 3-cycle key_up press with cnt_val=5: exactly one step_up, one cycle after the press edge. state returns to 0 after release.
- key_up held 30 cycles with cnt_val=5: steps at relative cycles 0, 10, 14, 18, 22, 26, for 6 pulses in total.
- key_up and key_dn rising on the same edge: no steps, state=3 until both are low. A subsequent key_dn press then gives one step_dn.
- key_up held, key_dn raised at cycle 12: steps at cycles 0 and 10 only, then state=3 with no further pulses.
- cnt_val=255 and a key_up press: step_up=0 and sat=1 for one cycle. cnt_val=0 with key_dn behaves the same way.
- rst raised during REPEAT: outputs go to 0 immediately. With the key still held after release, step_up fires on the first edge. Without KEY_REPEAT_EN, a 30-cycle hold yields one pulse.

Source files
------------

// File: rtl/key_step_ctrl.sv
// key_step_ctrl: turns debounced up/down key levels into single-cycle step
// pulses for the 8-bit up/down counter, with hold-to-repeat, lockout of
// conflicting presses and suppression of steps past the counter limits.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : HOLD -> REPEAT auto-repeat with a 24-bit cycle timer.
//   undefined : HOLD acts as a plain wait-for-release state, one step per press.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   key_up   in   debounced up-key level (1 = pressed)
//   key_dn   in   debounced down-key level (1 = pressed)
//   cnt_val  in   [7:0] counter value fed back from the counter
//   step_up  out  one-cycle increment pulse
//   step_dn  out  one-cycle decrement pulse
//   sat      out  one-cycle flag: a requested step was suppressed at a limit
//   state    out  [2:0] FSM state (IDLE=0, HOLD=1, REPEAT=2, LOCK=3)
module key_step_ctrl #(
    parameter logic [23:0] HOLD_CYC   = 24'd5_000_000,
    parameter logic [23:0] REPEAT_CYC = 24'd2_500_000,
    parameter logic [7:0]  CNT_MAX    = 8'd255,
    parameter logic [7:0]  CNT_MIN    = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_dn,
    input  logic [7:0] cnt_val,
    output logic       step_up,
    output logic       step_dn,
    output logic       sat,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        REPEAT = 3'd2,
        LOCK   = 3'd3
    } state_t;

    // Both timing parameters must leave at least one settle cycle for cnt_val.
    if (HOLD_CYC < 24'd2 || REPEAT_CYC < 24'd2) begin : g_bad_cfg
        $error("key_step_ctrl: HOLD_CYC and REPEAT_CYC must be >= 2");
    end

    state_t fsm;
    logic   owner;      // 0 = up key started the sequence, 1 = down key

    logic owner_key;
    logic other_key;
    logic req_dn;
    logic step_ok;

    // Direction of a step request: the pressed key in IDLE, else the owner.
    always_comb begin
        owner_key = owner ? key_dn : key_up;
        other_key = owner ? key_up : key_dn;
        req_dn    = (fsm == IDLE) ? key_dn : owner;
        step_ok   = req_dn ? (cnt_val > CNT_MIN) : (cnt_val < CNT_MAX);
    end

    assign state = fsm;

`ifdef KEY_REPEAT_EN
    logic [23:0] timer;
    logic [23:0] expiry;

    // Expiry count for the current timed state.
    always_comb begin
        expiry = (fsm == HOLD) ? (HOLD_CYC - 24'd1) : (REPEAT_CYC - 24'd1);
    end

    // Sequencer with auto-repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            owner   <= 1'b0;
            timer   <= 24'd0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            sat     <= 1'b0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            sat     <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (key_up && key_dn) begin
                        fsm <= LOCK;
                    end else if (key_up || key_dn) begin
                        owner   <= key_dn;
                        timer   <= 24'd0;
                        fsm     <= HOLD;
                        step_up <= !req_dn && step_ok;
                        step_dn <= req_dn && step_ok;
                        sat     <= !step_ok;
                    end
                end
                HOLD, REPEAT: begin
                    // Release wins over lockout, lockout wins over expiry.
                    if (!owner_key) begin
                        fsm <= IDLE;
                    end else if (other_key) begin
                        fsm <= LOCK;
                    end else if (timer == expiry) begin
                        timer   <= 24'd0;
                        fsm     <= REPEAT;
                        step_up <= !req_dn && step_ok;
                        step_dn <= req_dn && step_ok;
                        sat     <= !step_ok;
                    end else begin
                        timer <= timer + 24'd1;
                    end
                end
                LOCK: begin
                    if (!key_up && !key_dn) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
`else
    // Sequencer without auto-repeat: HOLD only waits for release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            owner   <= 1'b0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            sat     <= 1'b0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            sat     <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (key_up && key_dn) begin
                        fsm <= LOCK;
                    end else if (key_up || key_dn) begin
                        owner   <= key_dn;
                        fsm     <= HOLD;
                        step_up <= !req_dn && step_ok;
                        step_dn <= req_dn && step_ok;
                        sat     <= !step_ok;
                    end
                end
                HOLD: begin
                    if (!owner_key) begin
                        fsm <= IDLE;
                    end else if (other_key) begin
                        fsm <= LOCK;
                    end
                end
                LOCK: begin
                    if (!key_up && !key_dn) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
`endif

endmodule
